// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared constants and helpers for the counter_ext family.
//   - DIR_UP / DIR_DOWN : encoding of the dir_i input
//   - MODE_WRAP / MODE_SAT : encoding of the sat_i input
//   - clog2() : ceiling log2, used to size the optional prescaler phase counter
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Ceiling log2 with a floor of 1 so a register width is never zero.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_ext_if.sv
// -----------------------------------------------------------------------------
// counter_ext_if
//   Control/status bundle of counter_ext. clk/rst are kept outside as plain
//   ports.
//   Controls (master -> slave):
//     en_i       count enable
//     dir_i      1 = up, 0 = down
//     sat_i      1 = saturate at bounds, 0 = wrap
//     load_i     synchronous parallel load strobe
//     load_val_i load value (clamped to max_i)
//     max_i      inclusive upper bound, range 0..max_i
//     clr_ovf_i  clears the sticky overflow flag
//   Status (slave -> master):
//     data_o     current count
//     tc_o       one-cycle terminal-count pulse
//     ovf_o      sticky boundary-event flag
//   Parameter WIDTH: data-path width in bits.
// -----------------------------------------------------------------------------
interface counter_ext_if #(
  parameter int WIDTH = 4
);

  logic             en_i;
  logic             dir_i;
  logic             sat_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] max_i;
  logic             clr_ovf_i;
  logic [WIDTH-1:0] data_o;
  logic             tc_o;
  logic             ovf_o;

  modport master (
    output en_i, dir_i, sat_i, load_i, load_val_i, max_i, clr_ovf_i,
    input  data_o, tc_o, ovf_o
  );

  modport slave (
    input  en_i, dir_i, sat_i, load_i, load_val_i, max_i, clr_ovf_i,
    output data_o, tc_o, ovf_o
  );

endinterface

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Divides the count enable: tick_o fires on every PRESCALE-th cycle in which
//   en_i is high. The phase only advances while en_i=1 and holds otherwise.
//   Ports:
//     clk_i   clock, rising edge
//     rst_i   asynchronous active-high reset, phase -> 0
//     en_i    enable; advances the phase
//     clr_i   synchronous phase clear (driven by the counter's load strobe)
//     tick_o  combinational tick, valid in the cycle whose edge counts
//   Parameter PRESCALE: divide ratio (>= 2).
// -----------------------------------------------------------------------------
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int             PW   = clog2(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // The tick is taken from the current phase so the counter moves on the
  // same edge that sees the PRESCALE-th enabled cycle.
  assign tick_o = en_i & ~clr_i & (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/counter_ext.sv
// -----------------------------------------------------------------------------
// counter_ext
//   Parametrised up/down event/timebase counter with runtime modulo (max_i),
//   wrap or saturate at the bounds, parallel load, one-cycle terminal-count
//   pulse and a sticky overflow flag.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  asynchronous active-high reset
//     bus    counter_ext_if.slave (controls in, data_o/tc_o/ovf_o out)
//   Parameters:
//     WIDTH     counter width (>= 2)
//     PRESCALE  enable divide ratio (>= 2), only used when the macro
//               COUNTER_EXT_PRESCALE_EN is defined; otherwise every enabled
//               cycle is a count event.
// -----------------------------------------------------------------------------
module counter_ext
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  counter_ext_if.slave  bus
);

  if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
    $error("counter_ext: WIDTH and PRESCALE must both be >= 2");
  end

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             count_event;
  logic             boundary;

`ifdef COUNTER_EXT_PRESCALE_EN
  logic tick;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (bus.en_i),
    .clr_i  (bus.load_i),
    .tick_o (tick)
  );

  assign count_event = tick;
`else
  assign count_event = bus.en_i;
`endif

  // Next-count logic. Load beats counting; a count event at a bound is a
  // boundary event in both wrap and saturate mode. Up-boundary uses >= so a
  // max_i lowered below the current count is handled on the next up event,
  // while down events simply decrement from wherever the count is.
  always_comb begin
    data_d   = data_q;
    boundary = 1'b0;
    if (bus.load_i) begin
      data_d = (bus.load_val_i > bus.max_i) ? bus.max_i : bus.load_val_i;
    end else if (count_event) begin
      if (bus.dir_i == DIR_UP) begin
        if (data_q >= bus.max_i) begin
          boundary = 1'b1;
          data_d   = (bus.sat_i == MODE_SAT) ? bus.max_i : '0;
        end else begin
          data_d = data_q + WIDTH'(1);
        end
      end else begin
        if (data_q == '0) begin
          boundary = 1'b1;
          data_d   = (bus.sat_i == MODE_SAT) ? '0 : bus.max_i;
        end else begin
          data_d = data_q - WIDTH'(1);
        end
      end
    end
  end

  // A boundary event setting the flag outranks a concurrent clear request.
  always_comb begin
    tc_d  = boundary;
    ovf_d = boundary | (ovf_q & ~bus.clr_ovf_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.tc_o   = tc_q;
  assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_counter_ext.sv
// -----------------------------------------------------------------------------
// tb_counter_ext
//   Self-checking bench for counter_ext (WIDTH=4, PRESCALE=4). A behavioural
//   model tracks the expected count with plain integers; directed scenarios
//   plus a randomized run compare data_o/tc_o/ovf_o against it.
// -----------------------------------------------------------------------------
module tb_counter_ext;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  counter_ext_if #(.WIDTH(WIDTH)) bus ();

  counter_ext #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int m_data;
  int m_enabled_cycles;
  bit m_tc;
  bit m_ovf;

  // Reference model state goes back to its power-on values.
  task automatic model_reset();
    m_data           = 0;
    m_tc             = 1'b0;
    m_ovf            = 1'b0;
    m_enabled_cycles = 0;
  endtask

  // Reference model of one rising edge, written from the behavioural rules.
  task automatic model_edge();
    int mx;
    int lv;
    bit ev;
    bit bnd;
    mx  = int'(bus.max_i);
    lv  = int'(bus.load_val_i);
    bnd = 1'b0;
    ev  = 1'b0;
    if (bus.load_i) begin
      m_data           = (lv > mx) ? mx : lv;
      m_enabled_cycles = 0;
    end else begin
`ifdef COUNTER_EXT_PRESCALE_EN
      if (bus.en_i) begin
        m_enabled_cycles = m_enabled_cycles + 1;
        ev = (m_enabled_cycles % PRESCALE) == 0;
      end
`else
      ev = bus.en_i;
`endif
      if (ev) begin
        if (bus.dir_i) begin
          if (m_data + 1 > mx) begin
            bnd    = 1'b1;
            m_data = bus.sat_i ? mx : 0;
          end else begin
            m_data = m_data + 1;
          end
        end else begin
          if (m_data == 0) begin
            bnd    = 1'b1;
            m_data = bus.sat_i ? 0 : mx;
          end else begin
            m_data = m_data - 1;
          end
        end
      end
    end
    m_tc  = bnd;
    m_ovf = bnd | (m_ovf & ~bus.clr_ovf_i);
  endtask

  // One clock: model updates on the edge, outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input bit en, input bit dir, input bit sat,
                               input bit load, input int lv, input int mx,
                               input bit clr);
    bus.en_i       = en;
    bus.dir_i      = dir;
    bus.sat_i      = sat;
    bus.load_i     = load;
    bus.load_val_i = WIDTH'(lv);
    bus.max_i      = WIDTH'(mx);
    bus.clr_ovf_i  = clr;
  endtask

  task automatic test_reset();
    applyStimulus(0, 1, 0, 0, 0, 15, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_total++;
    if ({bus.data_o, bus.tc_o, bus.ovf_o} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_initial: got data=%0d tc=%b ovf=%b, want 0/0/0",
               bus.data_o, bus.tc_o, bus.ovf_o);
    end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, 15, 0);
    repeat (6) step();
    n_total++;
    if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
      n_bad++;
      $display("[TB] FAIL pre_reset_count: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
               bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_total++;
    if ({bus.data_o, bus.tc_o, bus.ovf_o} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset: got data=%0d tc=%b ovf=%b, want 0/0/0",
               bus.data_o, bus.tc_o, bus.ovf_o);
    end
    #24;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL restart[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 i, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
  endtask

  task automatic test_wrap_up();
    int tc_seen;
    tc_seen = 0;
    applyStimulus(0, 1, 0, 1, 0, 9, 0);
    step();
    applyStimulus(1, 1, 0, 0, 0, 9, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.tc_o === 1'b1) tc_seen++;
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL wrap_up[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 i, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
`ifndef COUNTER_EXT_PRESCALE_EN
    n_total++;
    if (tc_seen != 1 || bus.data_o !== 4'd2 || bus.ovf_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wrap_summary: got tc_pulses=%0d data=%0d ovf=%b, want 1/2/1",
               tc_seen, bus.data_o, bus.ovf_o);
    end
`endif
  endtask

  task automatic test_down_sat();
    int tc_seen;
    tc_seen = 0;
    applyStimulus(0, 0, 1, 1, 2, 9, 0);
    step();
    applyStimulus(1, 0, 1, 0, 0, 9, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.tc_o === 1'b1) tc_seen++;
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL down_sat[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 i, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
`ifndef COUNTER_EXT_PRESCALE_EN
    n_total++;
    if (tc_seen != 2 || bus.data_o !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL down_sat_summary: got tc_pulses=%0d data=%0d, want 2/0",
               tc_seen, bus.data_o);
    end
`endif
  endtask

  task automatic test_load_clamp();
    applyStimulus(1, 1, 0, 1, 12, 9, 0);
    step();
    n_total++;
    if (bus.data_o !== 4'd9 || bus.tc_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL load_clamp: got data=%0d tc=%b, want 9/0",
               bus.data_o, bus.tc_o);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2) == 0, 1, 0, 0, 0, 9, 0);
      step();
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL load_toggle[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 i, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
  endtask

  task automatic test_ovf_clear();
    applyStimulus(0, 1, 0, 1, 9, 9, 0);
    step();
    applyStimulus(1, 1, 0, 0, 0, 9, 1);
    step();
    n_total++;
    if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
      n_bad++;
      $display("[TB] FAIL ovf_set_wins: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
               bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
    end
`ifndef COUNTER_EXT_PRESCALE_EN
    n_total++;
    if (bus.ovf_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL ovf_set_wins_const: got ovf=%b, want 1", bus.ovf_o);
    end
`endif
    applyStimulus(0, 1, 0, 0, 0, 9, 1);
    step();
    n_total++;
    if (bus.ovf_o !== 1'b0 || bus.tc_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ovf_clear: got ovf=%b tc=%b, want 0/0", bus.ovf_o, bus.tc_o);
    end
    applyStimulus(0, 1, 0, 0, 0, 9, 0);
  endtask

  task automatic test_max_lowered();
    // Each row: sat, dir after lowering max from 15 to 5 with count at 8.
    bit row_sat [3] = '{0, 1, 0};
    bit row_dir [3] = '{1, 1, 0};
    for (int r = 0; r < 3; r++) begin
      applyStimulus(0, 1, 0, 1, 8, 15, 0);
      step();
      applyStimulus(1, row_dir[r], row_sat[r], 0, 0, 5, 0);
      repeat (PRESCALE) begin
        step();
        if (m_tc || m_data != 8) break;
      end
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL max_lowered[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 r, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
  endtask

  task automatic test_max_zero();
    applyStimulus(0, 1, 0, 1, 7, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, (i % 2) == 0, (i / 2) % 2 == 1, 0, 0, 0, 0);
      step();
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL max_zero[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 i, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
  endtask

  task automatic test_random();
    int mx;
    mx = 11;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mx = $urandom_range(0, 15);
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15), mx, $urandom_range(0, 9) == 0);
      step();
      n_total++;
      if ({bus.data_o, bus.tc_o, bus.ovf_o} !== {WIDTH'(m_data), m_tc, m_ovf}) begin
        n_bad++;
        $display("[TB] FAIL random[%0d]: got data=%0d tc=%b ovf=%b, want %0d/%b/%b",
                 i, bus.data_o, bus.tc_o, bus.ovf_o, m_data, m_tc, m_ovf);
      end
    end
  endtask

`ifdef COUNTER_EXT_PRESCALE_EN
  task automatic test_prescale();
    applyStimulus(0, 1, 0, 1, 0, 15, 0);
    step();
    applyStimulus(1, 1, 0, 0, 0, 15, 0);
    repeat (16) step();
    n_total++;
    if (bus.data_o !== 4'd4) begin
      n_bad++;
      $display("[TB] FAIL prescale_16: got data=%0d, want 4", bus.data_o);
    end
    applyStimulus(1, 1, 0, 0, 0, 15, 0);
    repeat (2) step();
    applyStimulus(0, 1, 0, 0, 0, 15, 0);
    repeat (5) step();
    applyStimulus(1, 1, 0, 0, 0, 15, 0);
    repeat (2) step();
    n_total++;
    if (bus.data_o !== 4'd5 || WIDTH'(m_data) !== 4'd5) begin
      n_bad++;
      $display("[TB] FAIL prescale_hold: got data=%0d, want 5", bus.data_o);
    end
  endtask
`endif

  initial begin
    $display("[TB] counter_ext bench start");
    test_reset();
    test_wrap_up();
    test_down_sat();
    test_load_clamp();
    test_ovf_clear();
    test_max_lowered();
    test_max_zero();
`ifdef COUNTER_EXT_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
